// File: rtl/cv_disp_sched_if.sv
// Bundle between the entry/analyzer side and the cv_disp_sched display scheduler.
// master = stimulus side, slave = scheduler.
interface cv_disp_sched_if;
  logic        CE;
  logic        KEY_CE;
  logic [31:0] SEQ_IN;
  logic [15:0] NOM_IN;
  logic [31:0] HEX_OUT;
  logic [7:0]  BLANK_OUT;
  logic [7:0]  DP_OUT;
  logic [1:0]  PAGE;
  logic [15:0] HIT_CNT;

  modport master (
    output CE, KEY_CE, SEQ_IN, NOM_IN,
    input  HEX_OUT, BLANK_OUT, DP_OUT, PAGE, HIT_CNT
  );

  modport slave (
    input  CE, KEY_CE, SEQ_IN, NOM_IN,
    output HEX_OUT, BLANK_OUT, DP_OUT, PAGE, HIT_CNT
  );
endinterface

// File: rtl/cv_disp_sched.sv
// Shares the 8-digit 7-seg between the entry page and the match-status page, flashing on new matches.
// Optional macro CV_DISP_AUTO_ROT_EN enables SEQ<->NOM dwell rotation and FLASH -> NOM exit.
module cv_disp_sched #(
  parameter int DWELL_MS = 2000,
  parameter int FLASH_MS = 500,
  parameter int BLINK_MS = 125,
  parameter int CNT_WDT  = 12
) (
  input logic             CLK,
  input logic             SYS_NRST,
  cv_disp_sched_if.slave  disp
);

  typedef enum logic [1:0] {
    ST_SEQ   = 2'b00,
    ST_NOM   = 2'b01,
    ST_FLASH = 2'b10
  } state_t;

  typedef logic [CNT_WDT-1:0] cnt_t;

  localparam cnt_t DWELL_LAST = cnt_t'(DWELL_MS - 1);
  localparam cnt_t FLASH_LAST = cnt_t'(FLASH_MS - 1);
  localparam cnt_t BLINK_LAST = cnt_t'(BLINK_MS - 1);
  localparam cnt_t CNT_ONE    = cnt_t'(1);

`ifdef CV_DISP_AUTO_ROT_EN
  localparam state_t SEQ_EXPIRY   = ST_NOM;
  localparam state_t FLASH_EXPIRY = ST_NOM;
`else
  localparam state_t SEQ_EXPIRY   = ST_SEQ;
  localparam state_t FLASH_EXPIRY = ST_SEQ;
`endif

  state_t      state, state_nxt;
  cnt_t        dwell_cnt, dwell_nxt;
  cnt_t        flash_cnt, flash_nxt;
  cnt_t        blink_cnt, blink_nxt;
  logic        blink_ph, blink_ph_nxt;
  logic [15:0] nom_prev;
  logic [15:0] hit_cnt, hit_nxt;
  logic [31:0] hex_q, hex_nxt;
  logic [7:0]  blank_q, blank_nxt;
  logic [7:0]  dp_q, dp_nxt;
  logic        newm;

  assign newm = (disp.NOM_IN != nom_prev) && (disp.NOM_IN != 16'h0000);

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    dwell_nxt    = dwell_cnt;
    flash_nxt    = flash_cnt;
    blink_nxt    = blink_cnt;
    blink_ph_nxt = blink_ph;
    hit_nxt      = hit_cnt;

    if (newm) begin
      if (hit_cnt != 16'hFFFF) hit_nxt = hit_cnt + 16'd1;
      state_nxt    = ST_FLASH;
      flash_nxt    = '0;
      blink_nxt    = '0;
      blink_ph_nxt = 1'b0;
    end else begin
      case (state)
        ST_SEQ: begin
          // Clear beats increment when the entry strobe and the tick coincide.
          if (disp.KEY_CE) begin
            dwell_nxt = '0;
          end else if (disp.CE) begin
            if (dwell_cnt == DWELL_LAST) begin
              dwell_nxt = '0;
              state_nxt = SEQ_EXPIRY;
            end else begin
              dwell_nxt = dwell_cnt + CNT_ONE;
            end
          end
        end
        ST_NOM: begin
          if (disp.KEY_CE) begin
            dwell_nxt = '0;
            state_nxt = ST_SEQ;
          end else if (disp.CE) begin
            if (dwell_cnt == DWELL_LAST) begin
              dwell_nxt = '0;
              state_nxt = ST_SEQ;
            end else begin
              dwell_nxt = dwell_cnt + CNT_ONE;
            end
          end
        end
        ST_FLASH: begin
          if (disp.CE) begin
            if (flash_cnt == FLASH_LAST) begin
              dwell_nxt = '0;
              state_nxt = FLASH_EXPIRY;
            end else begin
              flash_nxt = flash_cnt + CNT_ONE;
              if (blink_cnt == BLINK_LAST) begin
                blink_nxt    = '0;
                blink_ph_nxt = ~blink_ph;
              end else begin
                blink_nxt = blink_cnt + CNT_ONE;
              end
            end
          end
        end
        default: state_nxt = ST_SEQ;
      endcase
    end
  end

  // Page content follows the state being entered so outputs carry exactly one CLK of latency.
  always_comb begin
    hex_nxt   = disp.SEQ_IN;
    blank_nxt = 8'h00;
    dp_nxt    = 8'h01;
    case (state_nxt)
      ST_NOM: begin
        hex_nxt = {hit_nxt, disp.NOM_IN};
        dp_nxt  = 8'h10;
      end
      ST_FLASH: begin
        blank_nxt = blink_ph_nxt ? 8'hFF : 8'h00;
        dp_nxt    = 8'hFF;
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state     <= ST_SEQ;
      dwell_cnt <= '0;
      flash_cnt <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      nom_prev  <= '0;
      hit_cnt   <= '0;
      hex_q     <= '0;
      blank_q   <= 8'hFF;
      dp_q      <= 8'h00;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      flash_cnt <= flash_nxt;
      blink_cnt <= blink_nxt;
      blink_ph  <= blink_ph_nxt;
      nom_prev  <= disp.NOM_IN;
      hit_cnt   <= hit_nxt;
      hex_q     <= hex_nxt;
      blank_q   <= blank_nxt;
      dp_q      <= dp_nxt;
    end
  end

  assign disp.PAGE      = state;
  assign disp.HIT_CNT   = hit_cnt;
  assign disp.HEX_OUT   = hex_q;
  assign disp.BLANK_OUT = blank_q;
  assign disp.DP_OUT    = dp_q;

endmodule

// File: tb/tb_cv_disp_sched.sv
// Directed bench for cv_disp_sched: a tick-level page model checked every cycle plus literal spot checks.
// Honours CV_DISP_AUTO_ROT_EN the same way the design does.
module tb_cv_disp_sched;

  localparam int DWELL_T = 4;
  localparam int FLASH_T = 3;
  localparam int BLINK_T = 1;
  localparam logic [31:0] SEQ_VAL = 32'h1234_5678;

`ifdef CV_DISP_AUTO_ROT_EN
  localparam int ROT_PAGE = 1;
`else
  localparam int ROT_PAGE = 0;
`endif

  typedef struct {
    bit          live;
    int          page;
    int          ticks;
    int          hits;
    logic [15:0] prev;
    logic [31:0] seq;
  } model_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  model_t m;
  logic [65:0] got, want;

  cv_disp_sched_if bus ();

  cv_disp_sched #(
    .DWELL_MS(DWELL_T),
    .FLASH_MS(FLASH_T),
    .BLINK_MS(BLINK_T),
    .CNT_WDT (12)
  ) dut (
    .CLK     (clk),
    .SYS_NRST(rst_n),
    .disp    (bus)
  );

  always #5 clk = ~clk;

  // Page model in ticks-since-entry terms; FLASH and NOM pages both exit on their own tick limit.
  function automatic model_t model_step(model_t s, bit ce, bit key, logic [15:0] nom, logic [31:0] seq);
    model_t n;
    bit     newm;
    n      = s;
    newm   = (nom != s.prev) && (nom != 16'h0);
    n.prev = nom;
    n.seq  = seq;
    n.live = 1'b1;
    if (newm) begin
      n.hits  = (s.hits < 65535) ? s.hits + 1 : 65535;
      n.page  = 2;
      n.ticks = 0;
    end else if (s.page == 2) begin
      if (ce) n.ticks = s.ticks + 1;
      if (n.ticks == FLASH_T) begin
        n.page  = ROT_PAGE;
        n.ticks = 0;
      end
    end else if (key) begin
      n.page  = 0;
      n.ticks = 0;
    end else if (ce) begin
      n.ticks = s.ticks + 1;
      if (n.ticks == DWELL_T) begin
        n.ticks = 0;
        n.page  = (s.page == 1) ? 0 : ROT_PAGE;
      end
    end
    return n;
  endfunction

  function automatic logic [65:0] expect_of(model_t s);
    logic [31:0] hex;
    logic [7:0]  blank, dp;
    if (!s.live) return {2'b00, 16'h0000, 32'h0, 8'hFF, 8'h00};
    hex   = s.seq;
    blank = 8'h00;
    dp    = 8'h01;
    if (s.page == 1) begin
      hex = {16'(s.hits), s.prev};
      dp  = 8'h10;
    end else if (s.page == 2) begin
      blank = (((s.ticks / BLINK_T) % 2) != 0) ? 8'hFF : 8'h00;
      dp    = 8'hFF;
    end
    return {2'(s.page), 16'(s.hits), hex, blank, dp};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{live: 1'b0, page: 0, ticks: 0, hits: 0, prev: 16'h0, seq: 32'h0};
    end else begin
      m <= model_step(m, bus.CE, bus.KEY_CE, bus.NOM_IN, bus.SEQ_IN);
    end
  end

  // Every-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    got  = {bus.PAGE, bus.HIT_CNT, bus.HEX_OUT, bus.BLANK_OUT, bus.DP_OUT};
    want = expect_of(m);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL cycle_model t=%0t got page/hit/hex/blank/dp=%h want=%h", $time, got, want);
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic cyc(input bit ce, input bit key);
    bus.CE     = ce;
    bus.KEY_CE = key;
    @(negedge clk);
    bus.CE     = 1'b0;
    bus.KEY_CE = 1'b0;
  endtask

  task automatic tick(input bit key = 1'b0);
    cyc(1'b1, key);
    repeat (4) cyc(1'b0, 1'b0);
  endtask

  initial begin
    bus.CE     = 1'b0;
    bus.KEY_CE = 1'b0;
    bus.SEQ_IN = SEQ_VAL;
    bus.NOM_IN = 16'h0000;

    #2 rst_n = 1'b0;
    #1;
    check("reset_page",  32'(bus.PAGE),      32'h0);
    check("reset_blank", 32'(bus.BLANK_OUT), 32'hFF);
    check("reset_hex",   bus.HEX_OUT,        32'h0);
    check("reset_dp",    32'(bus.DP_OUT),    32'h0);
    check("reset_hit",   32'(bus.HIT_CNT),   32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("seq_page",  32'(bus.PAGE),      32'h0);
    check("seq_blank", 32'(bus.BLANK_OUT), 32'h00);
    check("seq_dp",    32'(bus.DP_OUT),    32'h01);
    check("seq_hex",   bus.HEX_OUT,        SEQ_VAL);

    // Auto-rotation after DWELL_T ticks and back.
    repeat (4) tick();
    check("rot_page", 32'(bus.PAGE),   32'(ROT_PAGE));
    check("rot_hex",  bus.HEX_OUT,     (ROT_PAGE == 1) ? 32'h0000_0000 : SEQ_VAL);
    check("rot_dp",   32'(bus.DP_OUT), (ROT_PAGE == 1) ? 32'h10 : 32'h01);
    repeat (4) tick();
    check("rot_back_page", 32'(bus.PAGE), 32'h0);

    // Entry strobe together with the 3rd tick restarts the dwell.
    tick();
    tick();
    tick(1'b1);
    repeat (3) tick();
    check("key_hold_page", 32'(bus.PAGE), 32'h0);
    tick();
    check("key_rot_page", 32'(bus.PAGE), 32'(ROT_PAGE));
    cyc(1'b0, 1'b1);
    check("key_nom_page", 32'(bus.PAGE), 32'h0);

    // First match flashes, blinks per tick, exits after FLASH_T ticks.
    bus.NOM_IN = 16'h0004;
    cyc(1'b0, 1'b0);
    check("newm_hit",   32'(bus.HIT_CNT),   32'd1);
    check("newm_page",  32'(bus.PAGE),      32'h2);
    check("newm_blank", 32'(bus.BLANK_OUT), 32'h00);
    check("newm_dp",    32'(bus.DP_OUT),    32'hFF);
    tick();
    check("blink1", 32'(bus.BLANK_OUT), 32'hFF);
    tick();
    check("blink2", 32'(bus.BLANK_OUT), 32'h00);
    tick();
    check("flash_exit_page", 32'(bus.PAGE), 32'(ROT_PAGE));

    // Drop to zero is not a match; re-match then restart the flash timer.
    bus.NOM_IN = 16'h0000;
    cyc(1'b0, 1'b0);
    check("zero_hit",  32'(bus.HIT_CNT), 32'd1);
    check("zero_page", 32'(bus.PAGE),    32'(ROT_PAGE));
    bus.NOM_IN = 16'h0004;
    cyc(1'b0, 1'b0);
    check("rematch_hit", 32'(bus.HIT_CNT), 32'd2);
    tick();
    tick();
    bus.NOM_IN = 16'h0008;
    cyc(1'b0, 1'b0);
    check("restart_hit",   32'(bus.HIT_CNT),   32'd3);
    check("restart_blank", 32'(bus.BLANK_OUT), 32'h00);
    tick();
    tick();
    check("restart_hold_page", 32'(bus.PAGE), 32'h2);
    tick();
    check("restart_exit_page", 32'(bus.PAGE), 32'(ROT_PAGE));

    // Match wins over entry strobe in the same cycle.
    bus.NOM_IN = 16'h0010;
    cyc(1'b0, 1'b1);
    check("newm_key_page", 32'(bus.PAGE),    32'h2);
    check("newm_key_hit",  32'(bus.HIT_CNT), 32'd4);

    // Drive the hit counter into saturation with back-to-back matches.
    for (int i = 0; i < 65540; i++) begin
      bus.NOM_IN = ((i % 2) != 0) ? 16'h0001 : 16'h0002;
      cyc(1'b0, 1'b0);
    end
    check("sat_hit", 32'(bus.HIT_CNT), 32'hFFFF);
    bus.NOM_IN = 16'h0004;
    cyc(1'b0, 1'b0);
    check("sat_hold_hit", 32'(bus.HIT_CNT), 32'hFFFF);

    // Asynchronous reset in the middle of FLASH.
    #2 rst_n = 1'b0;
    #1;
    check("midreset_page",  32'(bus.PAGE),      32'h0);
    check("midreset_hit",   32'(bus.HIT_CNT),   32'h0);
    check("midreset_blank", 32'(bus.BLANK_OUT), 32'hFF);
    check("midreset_hex",   bus.HEX_OUT,        32'h0);
    bus.NOM_IN = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tick();
    check("post_reset_page", 32'(bus.PAGE), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
